seq_add_sub: RTL
================

SEQ_ADD_SUB -- requirements
Module: seq_add_sub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 8, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, with N = WIDTH/CHUNK.
REQ-003 clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 in_valid_i  input  1  operands and mode valid.
REQ-006 in_ready_o  output  1  block can accept an operation.
REQ-007 data_1_i  input  WIDTH  operand A.
REQ-008 data_2_i  input  WIDTH  operand B.
REQ-009 sub_i  input  1  0 = add, 1 = subtract (A - B).
REQ-010 cin_i  input  1  carry-in for add; ignored for subtract.
REQ-011 out_valid_o  output  1  result fields valid.
REQ-012 out_ready_i  input  1  consumer accepts result.
REQ-013 data_o  output  WIDTH  result.
REQ-014 cout_o  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-015 overflow_o  output  1  two's-complement signed overflow.
REQ-016 zero_o  output  1  data_o == 0.

Function
REQ-017 The FSM SHALL have states IDLE, BUSY and DONE; in_ready_o SHALL be 1 only in IDLE, and out_valid_o SHALL be 1 only in DONE.
REQ-018 Accept occurs on a cycle with in_valid_i && in_ready_o: A, B, sub_i and cin_i are registered, the chunk counter is cleared, and the FSM moves IDLE->BUSY.
REQ-019 In BUSY, one CHUNK-bit slice per cycle, LSB slice first, SHALL be added as A_slice + B'_slice + carry, where B' = sub ? ~B : B and the initial carry = sub ? 1 : cin_i.
REQ-020 The slice sum SHALL be written into the matching slice of the result register, and the slice carry-out SHALL be registered as the next slice carry-in.
REQ-021 After slice N-1, the FSM SHALL move BUSY->DONE; out_valid_o SHALL assert exactly N cycles after the accept edge.
REQ-022 The chunk counter SHALL range 0..N-1 and SHALL NOT wrap or advance outside BUSY.
REQ-023 cout_o SHALL be the carry-out of slice N-1.
REQ-024 overflow_o SHALL be 1 iff A[MSB] == B'[MSB] and data_o[MSB] != A[MSB].
REQ-025 zero_o SHALL be 1 iff all WIDTH result bits are 0.
REQ-026 Results SHALL be bit-exact with the WIDTH-bit (A + B' + initial carry), including the carry bit.
REQ-027 Changes on input ports after accept SHALL NOT affect the operation in flight.
REQ-028 In DONE, data_o, cout_o, overflow_o and zero_o SHALL hold stable while out_ready_i == 0 (backpressure, unbounded).
REQ-029 DONE->IDLE SHALL occur on the cycle out_valid_o && out_ready_i; the next accept is possible no earlier than the following cycle (no accept in the same cycle as result handoff).
REQ-030 in_valid_i asserted in BUSY or DONE SHALL be ignored, without being queued.
REQ-031 With CHUNK == WIDTH, latency SHALL be 1 cycle (one BUSY cycle).

Reset
REQ-032 While rst_i is 1 at a clock edge, the FSM SHALL go to IDLE, and the counter, carry and result registers SHALL be cleared.
REQ-033 After reset: in_ready_o = 1, out_valid_o = 0, data_o = 0, cout_o = 0, overflow_o = 0, zero_o = 0.
REQ-034 Reset asserted in BUSY or DONE SHALL abort the operation with no out_valid_o pulse; the first accept after reset SHALL produce a correct result.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-035 Case 1: Add A=0xFFFFFFFF, B=0x00000001, cin=0 -> data_o=0x00000000, cout_o=1, zero_o=1, overflow_o=0, with out_valid_o 4 cycles after accept.
REQ-036 Case 2: Add A=0x7FFFFFFF, B=0x00000001 -> data_o=0x80000000, overflow_o=1, cout_o=0; add A=0x12345678, B=0x0F0F0F0F, cin=1 -> 0x21436588.
REQ-037 Case 3: Sub A=5, B=7 -> data_o=0xFFFFFFFE, cout_o=0, overflow_o=0; sub A=0x80000000, B=1 -> 0x7FFFFFFF, overflow_o=1, cout_o=1.
REQ-038 Case 4: out_ready_i held 0 for 10 cycles after a result -> outputs stable, in_ready_o=0, new in_valid_i ignored; out_ready_i=1 -> IDLE the next cycle.
REQ-039 Case 5: rst_i pulsed 1 cycle, 2 cycles after accept -> no result, IDLE with all outputs 0; the next operation is correct.
REQ-040 Case 6: Configurations CHUNK=32 (latency 1) and WIDTH=16, CHUNK=4 (latency 4) SHALL be exercised with random operands against a reference model.

Source files
------------

// File: rtl/seq_add_sub_if.sv
// Handshake and operand/result bundle for seq_add_sub.
// The consumer side (slave) is the adder; the master drives operations in and takes results.
interface seq_add_sub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] data_1_i;
    logic [WIDTH-1:0] data_2_i;
    logic             sub_i;
    logic             cin_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] data_o;
    logic             cout_o;
    logic             overflow_o;
    logic             zero_o;

    modport slave (
        input  in_valid_i, data_1_i, data_2_i, sub_i, cin_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, cout_o, overflow_o, zero_o
    );

    modport master (
        output in_valid_i, data_1_i, data_2_i, sub_i, cin_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, cout_o, overflow_o, zero_o
    );
endinterface

// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle, LSB slice first,
// with a ready/valid handshake on both the operand and the result side.
module seq_add_sub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    seq_add_sub_if.slave bus
);
    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;      // holds B' (already inverted for subtract)
    logic [WIDTH-1:0]  res_q;
    logic              carry_q;
    logic              cout_q;
    logic              ovf_q;
    logic              zero_q;
    logic [CntW-1:0]   cnt_q;

    logic [31:0]       base;
    logic [CHUNK:0]    slice_sum;
    logic [WIDTH-1:0]  res_next;

    always_comb begin
        base      = 32'(cnt_q) * CHUNK;
        slice_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
        res_next  = res_q;
        res_next[base +: CHUNK] = slice_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid_i) begin
                        a_q     <= bus.data_1_i;
                        b_q     <= bus.sub_i ? ~bus.data_2_i : bus.data_2_i;
                        carry_q <= bus.sub_i | bus.cin_i;
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    res_q   <= res_next;
                    carry_q <= slice_sum[CHUNK];
                    if (cnt_q == CntW'(N - 1)) begin
                        // Final slice: flags are taken from the completed result.
                        state_q <= StDone;
                        cout_q  <= slice_sum[CHUNK];
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (res_next[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q  <= (res_next == '0);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready_o  = (state_q == StIdle);
    assign bus.out_valid_o = (state_q == StDone);
    assign bus.data_o      = res_q;
    assign bus.cout_o      = cout_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.zero_o      = zero_q;
endmodule
